// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK transmit frame scheduler: FSM states and
// mux select encodings.
package bpsk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_PAY   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam logic SEL_PRE = 1'b0;
  localparam logic SEL_PAY = 1'b1;

endpackage

// File: rtl/bpsk_frame_sched_mux.sv
// Shared 2:1 datapath mux: input 0 is the preamble source, input 1 the payload source.
module bpsk_frame_sched_mux #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] y
);
  import bpsk_pkg::*;

  assign y = (sel == SEL_PAY) ? in1 : in0;

endmodule

// File: rtl/bpsk_frame_sched.sv
// Frame scheduler: sequences preamble words, payload words and idle gap cycles
// into one registered valid/ready output stream toward the modulator.
module bpsk_frame_sched #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned PRE_LEN = 32,
  parameter int unsigned PAY_LEN = 256,
  parameter int unsigned GAP_LEN = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_sig,
  input  logic             abort_sig,
  input  logic [WIDTH-1:0] pre_data,
  input  logic             pre_valid,
  output logic             pre_ready,
  input  logic [WIDTH-1:0] pay_data,
  input  logic             pay_valid,
  output logic             pay_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_first,
  output logic             out_last,
  output logic             sel_sig,
  output logic             busy
);
  import bpsk_pkg::*;

  localparam int unsigned MAX_LEN = (PRE_LEN > PAY_LEN) ? PRE_LEN : PAY_LEN;
  localparam int unsigned CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned GW      = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  localparam logic [CW-1:0] PRE_LAST = CW'(PRE_LEN - 1);
  localparam logic [CW-1:0] PAY_LAST = CW'(PAY_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  state_t            state, state_next;
  logic [CW-1:0]     word_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              pending;
  logic              adv, acc_pre, acc_pay, acc, out_xfer;
  logic [WIDTH-1:0]  mux_y;

  bpsk_frame_sched_mux #(.WIDTH(WIDTH)) u_mux (
    .sel (sel_sig),
    .in0 (pre_data),
    .in1 (pay_data),
    .y   (mux_y)
  );

  assign adv       = !out_valid || out_ready;
  assign pre_ready = (state == ST_PRE) && adv;
  assign pay_ready = (state == ST_PAY) && adv;
  assign acc_pre   = pre_ready && pre_valid;
  assign acc_pay   = pay_ready && pay_valid;
  assign acc       = acc_pre || acc_pay;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_sig || pending) state_next = ST_PRE;
      ST_PRE:   if (acc_pre && (word_cnt == PRE_LAST)) state_next = ST_PAY;
      ST_PAY:   if (acc_pay && (word_cnt == PAY_LAST)) state_next = ST_DRAIN;
      ST_DRAIN: if (out_xfer) state_next = (GAP_LEN == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:   if (gap_cnt == GAP_LAST) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (abort_sig) state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sel_sig   <= SEL_PRE;
      busy      <= 1'b0;
      pending   <= 1'b0;
      word_cnt  <= '0;
      gap_cnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state   <= state_next;
      sel_sig <= (state_next == ST_PAY) ? SEL_PAY : SEL_PRE;
      busy    <= (state_next != ST_IDLE);

      if (abort_sig) begin
        pending   <= 1'b0;
        word_cnt  <= '0;
        gap_cnt   <= '0;
        out_valid <= 1'b0;
        out_first <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        // In IDLE a start (or the queued one) launches directly, so pending only fills while busy.
        if (state == ST_IDLE) pending <= 1'b0;
        else if (start_sig)   pending <= 1'b1;

        // Any state change (PRE entry, PRE->PAY) restarts the word count.
        if (state_next != state) word_cnt <= '0;
        else if (acc)            word_cnt <= word_cnt + CW'(1);

        if ((state == ST_GAP) && (state_next == ST_GAP)) gap_cnt <= gap_cnt + GW'(1);
        else                                              gap_cnt <= '0;

        if (acc) begin
          out_data  <= mux_y;
          out_valid <= 1'b1;
          out_first <= acc_pre && (word_cnt == '0);
          out_last  <= acc_pay && (word_cnt == PAY_LAST);
        end else if (out_xfer) begin
          out_valid <= 1'b0;
          out_first <= 1'b0;
          out_last  <= 1'b0;
        end
      end
    end
  end

endmodule
